mux_slot_sequencer: RTL

//  Hosts NUM_SLOTS TinyTapeout project slots behind a single user pin set, selecting at most one active slot.

---
 rtl/mux_slot_pkg.sv | 34 +++
 rtl/mux_slot_outreg.sv | 47 ++++
 rtl/mux_slot_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mux_slot_pkg.sv
// Shared types and helpers for the TinyTapeout slot multiplexer.
// Slot bus packing: iw = {uio_in, ui_in, rst_n, clk}, ow = {uio_oe, uio_out, uo_out}.
package mux_slot_pkg;

    localparam int IW_W = 18;
    localparam int OW_W = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_RESET,
        S_ACTIVE
    } state_t;

    typedef struct packed {
        logic [7:0] oe;
        logic [7:0] uio;
        logic [7:0] uo;
    } ow_t;

    function automatic logic [IW_W-1:0] iw_pack(
        input logic [7:0] uio,
        input logic [7:0] ui,
        input logic       rst_n,
        input logic       clk
    );
        return {uio, ui, rst_n, clk};
    endfunction

    function automatic ow_t ow_unpack(input logic [OW_W-1:0] ow);
        return ow_t'(ow);
    endfunction

endpackage

// File: rtl/mux_slot_outreg.sv
// Output path: selects the active slot's ow word and registers it.
// The register loads zero whenever keep is low, so idle/switching slots never leak.
module mux_slot_outreg
    import mux_slot_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SEL_W     = $clog2(NUM_SLOTS) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SLOTS*OW_W-1:0] slot_ow,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      keep,
    output logic [7:0]                uo_out,
    output logic [7:0]                uio_out,
    output logic [7:0]                uio_oe
);

    logic [OW_W-1:0] pick;
    ow_t             q;

    // NUM_SLOTS:1 mux of the slot output words
    always_comb begin
        pick = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sel == SEL_W'(i)) begin
                pick = slot_ow[OW_W*i +: OW_W];
            end
        end
    end

    // capture selected word, forced to zero outside a steady active slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (keep) begin
            q <= ow_unpack(pick);
        end else begin
            q <= '0;
        end
    end

    assign uo_out  = q.uo;
    assign uio_out = q.uio;
    assign uio_oe  = q.oe;

endmodule

// File: rtl/mux_slot_sequencer.sv
// Hosts NUM_SLOTS project slots behind one pin set; switches are sequenced
// drain -> clocked reset -> active. err_pulse is registered (cycle after accept).
module mux_slot_sequencer
    import mux_slot_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SEL_W     = $clog2(NUM_SLOTS) + 1,
    parameter int DRAIN_CYC = 2,
    parameter int RST_HOLD  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      proj_clk,
    input  logic                      host_rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SEL_W-1:0]          req_id,
    input  logic [7:0]                ui_in,
    input  logic [7:0]                uio_in,
    output logic [7:0]                uo_out,
    output logic [7:0]                uio_out,
    output logic [7:0]                uio_oe,
    output logic [NUM_SLOTS-1:0]      slot_ena,
    output logic [NUM_SLOTS*IW_W-1:0] slot_iw,
    input  logic [NUM_SLOTS*OW_W-1:0] slot_ow,
    output logic [SEL_W-1:0]          active_id,
    output logic                      active_valid,
    output logic                      err_pulse
);

    localparam int CNT_MAX = (DRAIN_CYC > RST_HOLD) ? DRAIN_CYC : RST_HOLD;
    localparam int CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_HOLD - 1);
    localparam logic [SEL_W-1:0] N_ID     = SEL_W'(NUM_SLOTS);

    state_t               state, nxt;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [SEL_W-1:0]     tgt, tgt_n;
    logic [NUM_SLOTS-1:0] ena_n;
    logic                 err_n;
    logic                 acc;
    logic                 id_ok;
    logic                 tgt_ok;
    logic                 keep;

    assign req_ready    = (state == S_IDLE) || (state == S_ACTIVE);
    assign acc          = req_valid & req_ready;
    assign id_ok        = req_id < N_ID;
    assign tgt_ok       = tgt < N_ID;
    assign active_valid = (state == S_ACTIVE);
    assign active_id    = active_valid ? tgt : '0;
    assign keep         = (state == S_ACTIVE) && (nxt == S_ACTIVE);

    // next-state, counter/target updates and next slot enable
    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        tgt_n = tgt;
        err_n = 1'b0;
        ena_n = '0;
        unique case (state)
            S_IDLE: begin
                if (acc && id_ok) begin
                    nxt   = S_RESET;
                    cnt_n = RST_LD;
                    tgt_n = req_id;
                end else if (acc) begin
                    err_n = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == '0) begin
                    nxt   = tgt_ok ? S_RESET : S_IDLE;
                    cnt_n = RST_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_RESET: begin
                if (cnt == '0) begin
                    nxt = S_ACTIVE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (acc) begin
                    nxt   = S_DRAIN;
                    cnt_n = DRAIN_LD;
                    tgt_n = req_id;
                    err_n = !id_ok;
                end
            end
        endcase
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ena_n[i] = ((nxt == S_RESET) || (nxt == S_ACTIVE))
                       && (tgt_n == SEL_W'(i));
        end
    end

    // sequencer state, counter, target, enables and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tgt       <= '0;
            slot_ena  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_n;
            tgt       <= tgt_n;
            slot_ena  <= ena_n;
            err_pulse <= err_n;
        end
    end

    // per-slot input bus: only the target slot sees clock/reset/pins
    always_comb begin
        slot_iw = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (tgt == SEL_W'(i)) begin
                if (state == S_RESET) begin
                    slot_iw[IW_W*i +: IW_W] =
                        iw_pack(8'h00, 8'h00, 1'b0, proj_clk);
                end else if (state == S_ACTIVE) begin
                    slot_iw[IW_W*i +: IW_W] =
                        iw_pack(uio_in, ui_in, host_rst_n, proj_clk);
                end
            end
        end
    end

    mux_slot_outreg #(
        .NUM_SLOTS(NUM_SLOTS),
        .SEL_W    (SEL_W)
    ) u_outreg (
        .clk    (clk),
        .rst    (rst),
        .slot_ow(slot_ow),
        .sel    (tgt),
        .keep   (keep),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

endmodule
